mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the general-use memory port A between two masters: m0 (core load/store path) and m1 (debug loader/DMA).
- Grants one request per cycle and locks the port for atomic sequences.
- Steers read data back to the issuing master after the fixed synchronous read latency.
- Sits between the Hubris core's data port and port A of the unified memory.

Parameters:
ADDR_WIDTH, 32, address width of masters and memory port
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
READ_LATENCY, 1, cycles from accepted read to valid mem_dout (1..4)
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority with m0 highest

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
m0_req  input  1  m0 request valid
m0_we  input  DATA_WIDTH/8  m0 byte write enables; all zero = read
m0_addr  input  ADDR_WIDTH  m0 byte address
m0_wdata  input  DATA_WIDTH  m0 write data
m0_lock  input  1  m0 requests exclusive ownership
m0_gnt  output  1  m0 request accepted this cycle
m0_rvalid  output  1  m0 read data valid
m0_rdata  output  DATA_WIDTH  m0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata  same as m0, for m1
mem_en  output  1  memory port enable
mem_we  output  DATA_WIDTH/8  memory byte write enables
mem_addr  output  ADDR_WIDTH  memory address
mem_din  output  DATA_WIDTH  memory write data
mem_dout  input  DATA_WIDTH  memory read data, valid READ_LATENCY cycles after en
conflict_count  output  32  saturating count of cycles in which a request was denied

Behaviour:
- Reset values: all gnt, rvalid and mem_en are 0; mem_we, mem_addr, mem_din, rdata and conflict_count are 0.
- Also on reset: lock owner cleared, last_grant = m1 (so m0 wins the first conflict), read-tag pipeline cleared.
- Grant is combinational within the cycle.
- A transaction is accepted at the posedge where req & gnt.
- The mem_* outputs are a mux of the granted master's fields. mem_en = m0_gnt | m1_gnt.
- When no grant is given, mem_we = 0 and mem_en = 0.
- At most one gnt is high per cycle.
- A lone requester is granted immediately, unless the other master owns the lock.
- Conflict with PRIORITY_MODE=0: grant the master that is not last_grant. last_grant updates on every accepted transaction.
- Conflict with PRIORITY_MODE=1: m0 always wins.
- Lock set: when a master is granted with lock=1, lock_owner is registered to that master.
- While lock_owner is valid, only the owner can be granted. The other master's req is denied even if the owner is idle.
- Lock clear: lock_owner clears at the first posedge where the owner's lock=0. A grant in that same cycle is still given to the owner only.
- A locked grant does not suppress the round-robin update.
- Read return uses a READ_LATENCY-deep shift register of {valid, master_id}. It is pushed on every accepted read (we==0).
- At pipeline exit, raise the tagged master's rvalid for exactly 1 cycle and drive its rdata = mem_dout.
- The other master's rvalid stays 0. rdata holds its last value when rvalid=0.
- Writes produce no rvalid.
- Back-to-back reads from alternating masters return in issue order, one per cycle, with no bubbles.
- conflict_count increments when both req are high, or when the non-owner requests during a lock. It saturates at 0xFFFFFFFF.
- Reset mid-operation: in-flight reads are discarded and no rvalid is emitted afterwards. The lock is released.
- Simultaneous lock request by both masters in a conflict: the winner takes the lock and the loser is denied.

Test Plan:
1. Solo read: m0 reads 0x100 with mem word 0xDEADBEEF, READ_LATENCY=1 -> m0_gnt same cycle; m0_rvalid=1 and m0_rdata=0xDEADBEEF one cycle later; m1_rvalid stays 0.
2. Round-robin: both masters read continuously for 6 cycles after reset -> grants go m0,m1,m0,m1,m0,m1; rvalids return in the same order; conflict_count=6.
3. Fixed priority: PRIORITY_MODE=1, both request for 4 cycles -> m0 granted 4 times, m1 never granted; conflict_count=4.
4. Lock: m1 writes 0x200 with lock=1, then holds lock=1 while idle for 3 cycles while m0 requests -> m0_gnt=0 throughout. m1 drops lock -> m0 is granted the following cycle.
5. Latency and reset: READ_LATENCY=3, m0 reads at cycle 0, reset asserted at cycle 1 -> no m0_rvalid ever appears, and all outputs are 0 during reset.
6. Writes: m1 writes 0xCAFEF00D with we=4'b0011 -> mem_we=0011, mem_din=0xCAFEF00D in the grant cycle; no m1_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for memory port A: combinational grant, atomic lock,
// and tagged read-data return after the fixed memory read latency.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_req,
    input  logic [DATA_WIDTH/8-1:0]   m0_we,
    input  logic [ADDR_WIDTH-1:0]     m0_addr,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic                      m0_lock,
    output logic                      m0_gnt,
    output logic                      m0_rvalid,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    input  logic                      m1_req,
    input  logic [DATA_WIDTH/8-1:0]   m1_we,
    input  logic [ADDR_WIDTH-1:0]     m1_addr,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic                      m1_lock,
    output logic                      m1_gnt,
    output logic                      m1_rvalid,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic                      mem_en,
    output logic [DATA_WIDTH/8-1:0]   mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_din,
    input  logic [DATA_WIDTH-1:0]     mem_dout,
    output logic [31:0]               conflict_count
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                    lock_valid;
    logic                    lock_owner;
    logic                    last_grant;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_id;
    logic [DATA_WIDTH-1:0]   rdata0_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;
    logic [31:0]             count_q;
    logic                    accept_read;
    logic                    conflict;
    logic                    tail_valid;
    logic                    tail_id;

    // Grant selection: lock owner first, then priority / round-robin on conflict.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (lock_valid) begin
                m0_gnt = m0_req & ~lock_owner;
                m1_gnt = m1_req & lock_owner;
            end else if (m0_req && m1_req) begin
                if (PRIORITY_MODE != 0 || last_grant) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Memory port mux; idle port drives zeros.
    always_comb begin
        mem_en   = m0_gnt | m1_gnt;
        mem_we   = BE_WIDTH'(0);
        mem_addr = ADDR_WIDTH'(0);
        mem_din  = DATA_WIDTH'(0);
        if (m0_gnt) begin
            mem_we   = m0_we;
            mem_addr = m0_addr;
            mem_din  = m0_wdata;
        end else if (m1_gnt) begin
            mem_we   = m1_we;
            mem_addr = m1_addr;
            mem_din  = m1_wdata;
        end
    end

    assign accept_read = mem_en & (mem_we == BE_WIDTH'(0));
    assign conflict    = ~reset & ((m0_req & m1_req) |
                                   (lock_valid & (lock_owner ? m0_req : m1_req)));
    assign tail_valid  = pipe_valid[READ_LATENCY-1];
    assign tail_id     = pipe_id[READ_LATENCY-1];

    always_comb begin
        m0_rvalid = ~reset & tail_valid & ~tail_id;
        m1_rvalid = ~reset & tail_valid & tail_id;
        m0_rdata  = reset ? DATA_WIDTH'(0) : (m0_rvalid ? mem_dout : rdata0_q);
        m1_rdata  = reset ? DATA_WIDTH'(0) : (m1_rvalid ? mem_dout : rdata1_q);
    end

    assign conflict_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            last_grant <= 1'b1;
            pipe_valid <= '0;
            pipe_id    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            count_q    <= 32'd0;
        end else begin
            if (mem_en) begin
                last_grant <= m1_gnt;
            end
            // Lock release has priority; owner keeps the port until its lock drops.
            if (lock_valid && !(lock_owner ? m1_lock : m0_lock)) begin
                lock_valid <= 1'b0;
            end else if (m0_gnt && m0_lock) begin
                lock_valid <= 1'b1;
                lock_owner <= 1'b0;
            end else if (m1_gnt && m1_lock) begin
                lock_valid <= 1'b1;
                lock_owner <= 1'b1;
            end
            for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
            pipe_valid[0] <= accept_read;
            pipe_id[0]    <= m1_gnt;
            if (m0_rvalid) begin
                rdata0_q <= mem_dout;
            end
            if (m1_rvalid) begin
                rdata1_q <= mem_dout;
            end
            if (conflict && count_q != 32'hFFFF_FFFF) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations driven in parallel and
// compared against a transaction-level reference model each cycle.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic r0, r1, l0, l1;
    logic [3:0]  we0, we1;
    logic [31:0] a0, a1, d0, d1;

    logic [2:0] g0, g1, en, rv0, rv1;
    logic [2:0][3:0]  mwe;
    logic [2:0][31:0] maddr, mdin, mdout, rd0, rd1, cc;
    logic [31:0] dl [3][4];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat [3] = '{1, 1, 3};
    int pri [3] = '{0, 1, 0};

    int          lastg [3];
    bit          lkv   [3];
    int          lko   [3];
    longint      cnt   [3];
    bit          sv    [3][8];
    int          sw    [3][8];
    logic [31:0] sd    [3][8];
    logic [31:0] hold  [3][2];
    int          eg    [3];
    bit          econf [3];

    mem_port_arbiter #(.READ_LATENCY(1), .PRIORITY_MODE(0)) u_rr (
        .clk(clk), .reset(rst),
        .m0_req(r0), .m0_we(we0), .m0_addr(a0), .m0_wdata(d0), .m0_lock(l0),
        .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
        .m1_req(r1), .m1_we(we1), .m1_addr(a1), .m1_wdata(d1), .m1_lock(l1),
        .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
        .mem_en(en[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_din(mdin[0]),
        .mem_dout(mdout[0]), .conflict_count(cc[0]));

    mem_port_arbiter #(.READ_LATENCY(1), .PRIORITY_MODE(1)) u_fp (
        .clk(clk), .reset(rst),
        .m0_req(r0), .m0_we(we0), .m0_addr(a0), .m0_wdata(d0), .m0_lock(l0),
        .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
        .m1_req(r1), .m1_we(we1), .m1_addr(a1), .m1_wdata(d1), .m1_lock(l1),
        .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
        .mem_en(en[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_din(mdin[1]),
        .mem_dout(mdout[1]), .conflict_count(cc[1]));

    mem_port_arbiter #(.READ_LATENCY(3), .PRIORITY_MODE(0)) u_l3 (
        .clk(clk), .reset(rst),
        .m0_req(r0), .m0_we(we0), .m0_addr(a0), .m0_wdata(d0), .m0_lock(l0),
        .m0_gnt(g0[2]), .m0_rvalid(rv0[2]), .m0_rdata(rd0[2]),
        .m1_req(r1), .m1_we(we1), .m1_addr(a1), .m1_wdata(d1), .m1_lock(l1),
        .m1_gnt(g1[2]), .m1_rvalid(rv1[2]), .m1_rdata(rd1[2]),
        .mem_en(en[2]), .mem_we(mwe[2]), .mem_addr(maddr[2]), .mem_din(mdin[2]),
        .mem_dout(mdout[2]), .conflict_count(cc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A1234);
    endfunction

    // Synchronous-read memory per instance: read word appears after its latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 3; i > 0; i--) dl[k][i] <= dl[k][i-1];
            dl[k][0] <= (en[k] && mwe[k] == 4'h0) ? memfn(maddr[k]) : $urandom();
        end
    end
    assign mdout[0] = dl[0][0];
    assign mdout[1] = dl[1][0];
    assign mdout[2] = dl[2][2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            lastg[k] = 1; lkv[k] = 0; lko[k] = 0; cnt[k] = 0;
            hold[k][0] = '0; hold[k][1] = '0;
            for (int s = 0; s < 8; s++) sv[k][s] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            int g;
            bit conf;
            bit v;
            int slot;
            logic [3:0]  xwe;
            logic [31:0] xr0, xr1;
            g = -1; conf = 0;
            if (!rst) begin
                if (lkv[k]) begin
                    if (lko[k] == 0 && r0) g = 0;
                    if (lko[k] == 1 && r1) g = 1;
                    conf = (lko[k] == 0) ? r1 : r0;
                end else if (r0 && r1) begin
                    g = (pri[k] == 1) ? 0 : 1 - lastg[k];
                end else if (r0) begin
                    g = 0;
                end else if (r1) begin
                    g = 1;
                end
                if (r0 && r1) conf = 1;
            end
            eg[k] = g; econf[k] = conf;
            xwe = (g == 0) ? we0 : (g == 1) ? we1 : 4'h0;
            chk("m0_gnt", k, 32'(g0[k]), 32'(g == 0));
            chk("m1_gnt", k, 32'(g1[k]), 32'(g == 1));
            chk("mem_en", k, 32'(en[k]), 32'(g >= 0));
            chk("mem_we", k, 32'(mwe[k]), 32'(xwe));
            if (g >= 0) begin
                chk("mem_addr", k, maddr[k], (g == 0) ? a0 : a1);
                chk("mem_din", k, mdin[k], (g == 0) ? d0 : d1);
            end
            slot = cyc % 8;
            v = !rst && sv[k][slot];
            xr0 = rst ? 32'h0 : (v && sw[k][slot] == 0) ? sd[k][slot] : hold[k][0];
            xr1 = rst ? 32'h0 : (v && sw[k][slot] == 1) ? sd[k][slot] : hold[k][1];
            chk("m0_rvalid", k, 32'(rv0[k]), 32'(v && sw[k][slot] == 0));
            chk("m1_rvalid", k, 32'(rv1[k]), 32'(v && sw[k][slot] == 1));
            chk("m0_rdata", k, rd0[k], xr0);
            chk("m1_rdata", k, rd1[k], xr1);
            chk("conflict_count", k, cc[k], 32'(cnt[k]));
            if (v) begin
                hold[k][sw[k][slot]] = sd[k][slot];
                sv[k][slot] = 0;
            end
        end
    endtask

    task automatic update_all();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                int g;
                g = eg[k];
                if (g >= 0) begin
                    lastg[k] = g;
                    if (((g == 0) ? we0 : we1) == 4'h0) begin
                        sv[k][(cyc + lat[k]) % 8] = 1;
                        sw[k][(cyc + lat[k]) % 8] = g;
                        sd[k][(cyc + lat[k]) % 8] = memfn((g == 0) ? a0 : a1);
                    end
                end
                if (lkv[k] && !((lko[k] == 0) ? l0 : l1)) lkv[k] = 0;
                else if (g == 0 && l0) begin lkv[k] = 1; lko[k] = 0; end
                else if (g == 1 && l1) begin lkv[k] = 1; lko[k] = 1; end
                if (econf[k] && cnt[k] < 64'hFFFF_FFFF) cnt[k] = cnt[k] + 1;
            end
        end
        cyc++;
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        update_all();
        @(negedge clk);
    endtask

    task automatic idle();
        r0 = 0; r1 = 0; l0 = 0; l1 = 0; we0 = 4'h0; we1 = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        step();
        rst = 1'b0;

        // Solo read returns DEADBEEF one cycle later
        r0 = 1; a0 = 32'h100;
        step();
        idle();
        #1;
        chk("solo_rdata", 0, rd0[0], 32'hDEADBEEF);
        chk("solo_rvalid", 0, 32'(rv0[0]), 32'd1);
        repeat (4) step();

        // Continuous conflict after reset
        rst = 1'b1; step(); rst = 1'b0;
        r0 = 1; r1 = 1; a0 = 32'h40; a1 = 32'h80;
        repeat (6) step();
        idle();
        #1;
        chk("rr_cc6", 0, cc[0], 32'd6);
        chk("fp_cc6", 1, cc[1], 32'd6);
        chk("l3_cc6", 2, cc[2], 32'd6);
        repeat (4) step();

        // Lock held by idle m1 blocks m0
        r1 = 1; we1 = 4'hF; a1 = 32'h200; d1 = 32'h1111_2222; l1 = 1;
        step();
        r1 = 0; we1 = 4'h0; r0 = 1; a0 = 32'h300;
        repeat (3) step();
        l1 = 0;
        repeat (3) step();
        idle();

        // Partial write from m1
        r1 = 1; we1 = 4'b0011; a1 = 32'h204; d1 = 32'hCAFEF00D;
        step();
        idle();
        repeat (4) step();

        // Reset while a read is in flight
        r0 = 1; a0 = 32'h500;
        step();
        idle(); rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            we0 = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom());
            we1 = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom());
            a0 = $urandom(); a1 = $urandom();
            d0 = $urandom(); d1 = $urandom();
            l0 = ($urandom_range(0, 7) == 0);
            l1 = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
